// File: rtl/tracesys_pkg.sv
// Shared types and helpers for the trace system mux.
package tracesys_pkg;

  localparam int PKT_CNT_W = 16;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tracesys_skid_buffer.sv
// Two-entry registered skid buffer; upstream ready comes straight from a flop.
module tracesys_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (skid_valid) begin
      // Upstream is stalled while the skid holds a beat; drain it first.
      if (out_ready) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (in_valid) begin
      if (!out_valid || out_ready) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tracesys_mux_rr.sv
// Packet-granular round-robin Avalon-ST mux with channel tagging.
// Optional per-input packet counters under TRACESYS_MUX_STATS_EN.
module tracesys_mux_rr
  import tracesys_pkg::*;
#(
  parameter int NUM_INPUTS    = 2,
  parameter int DATA_WIDTH    = 8,
  localparam int CHANNEL_WIDTH = clog2_min1(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_startofpacket,
  input  logic [NUM_INPUTS-1:0]            in_endofpacket,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CHANNEL_WIDTH-1:0]         out_channel,
  output logic                             out_startofpacket,
  output logic                             out_endofpacket
`ifdef TRACESYS_MUX_STATS_EN
  ,
  input  logic                             stats_clear,
  output logic [NUM_INPUTS*PKT_CNT_W-1:0]  pkt_count
`endif
);

  localparam int CH_W  = CHANNEL_WIDTH;
  localparam int PAY_W = CH_W + 2 + DATA_WIDTH;

  arb_state_e      state, state_n;
  logic [CH_W-1:0] rr_ptr, rr_ptr_n, grant, grant_n;
  logic [CH_W-1:0] winner, sel;
  logic            found, sel_valid, sel_eop, accept;
  logic            skid_ready, acc_ready;
  logic [PAY_W-1:0] pay_in, pay_out;

  function automatic logic [CH_W-1:0] next_idx(input logic [CH_W-1:0] idx);
    return (idx == CH_W'(NUM_INPUTS-1)) ? '0 : idx + 1'b1;
  endfunction

  assign acc_ready = skid_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      grant  <= grant_n;
    end
  end

  always_comb begin
    found     = 1'b0;
    winner    = '0;
    in_ready  = '0;
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    grant_n   = grant;
    // First valid input at or above rr_ptr, wrapping.
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!found && in_valid[(int'(rr_ptr) + k) % NUM_INPUTS]) begin
        found  = 1'b1;
        winner = CH_W'((int'(rr_ptr) + k) % NUM_INPUTS);
      end
    end
    sel       = (state == ARB_LOCKED) ? grant : winner;
    sel_valid = (state == ARB_LOCKED) ? in_valid[sel] : found;
    sel_eop   = in_endofpacket[sel];
    if (state == ARB_LOCKED || found) in_ready[sel] = acc_ready;
    accept = sel_valid && acc_ready;
    if (accept) begin
      if (sel_eop) begin
        state_n  = ARB_IDLE;
        rr_ptr_n = next_idx(sel);
      end else if (state == ARB_IDLE) begin
        state_n = ARB_LOCKED;
        grant_n = sel;
      end
    end
  end

  assign pay_in = {sel, in_startofpacket[sel], sel_eop,
                   in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH]};

  tracesys_skid_buffer #(.WIDTH(PAY_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sel_valid),
    .in_ready  (skid_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_channel, out_startofpacket, out_endofpacket, out_data} = pay_out;

`ifdef TRACESYS_MUX_STATS_EN
  // Clear has priority over a same-cycle EOP increment.
  always_ff @(posedge clk) begin
    if (reset || stats_clear)
      pkt_count <= '0;
    else if (accept && sel_eop)
      pkt_count[int'(sel)*PKT_CNT_W +: PKT_CNT_W] <=
        pkt_count[int'(sel)*PKT_CNT_W +: PKT_CNT_W] + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tracesys_mux_rr.sv
// Randomized bench for tracesys_mux_rr against a queue-based reference model.
module tb_tracesys_mux_rr;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid, in_ready, in_sop, in_eop;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_ready, out_sop, out_eop;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_channel;

  always #5 clk = ~clk;

  tracesys_mux_rr #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_sop),
    .in_endofpacket    (in_eop),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_sop),
    .out_endofpacket   (out_eop)
  );

  typedef struct { logic sop; logic eop; logic [DW-1:0] data; } beat_t;
  typedef struct { int ch; beat_t b; } obeat_t;

  beat_t  srcq[N][$];   // pending beats per source
  obeat_t sb[$];        // beats accepted but not yet taken downstream
  int     ptr  = 0;     // next input to favour when idle
  int     open = -1;    // input owning the packet in progress, -1 if none
  int     vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_and_drive(input int vpct, input int maxlen, input int newpct);
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() == 0 && $urandom_range(99) < newpct) begin
        int len = $urandom_range(maxlen, 1);
        for (int j = 0; j < len; j++) begin
          beat_t b;
          b.sop  = (j == 0);
          b.eop  = (j == len - 1);
          b.data = DW'($urandom);
          srcq[i].push_back(b);
        end
      end
      if (srcq[i].size() > 0) begin
        in_valid[i]           = ($urandom_range(99) < vpct);
        in_sop[i]             = srcq[i][0].sop;
        in_eop[i]             = srcq[i][0].eop;
        in_data[i*DW +: DW]   = srcq[i][0].data;
      end else begin
        in_valid[i]           = 1'b0;
        in_sop[i]             = 1'($urandom);
        in_eop[i]             = 1'($urandom);
        in_data[i*DW +: DW]   = DW'($urandom);
      end
    end
  endtask

  initial begin
    logic [N-1:0] exp_rdy;
    logic         was_reset;
    int           acc_i;
    bit           drain;
    int           vpct, rpct, maxlen, newpct;

    reset = 1'b1; out_ready = 1'b0;
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0;
    was_reset = 1'b0;

    for (int cyc = 0; cyc < 1000; cyc++) begin
      // Phases: random traffic, continuous single-beat streams, gappy long packets
      if (cyc < 400)      begin vpct = 70;  rpct = 60;  maxlen = 4; newpct = 50;  end
      else if (cyc < 650) begin vpct = 100; rpct = 100; maxlen = 1; newpct = 100; end
      else                begin vpct = 40;  rpct = 50;  maxlen = 6; newpct = 60;  end
      reset = (cyc < 3) || (cyc == 300) || (cyc == 820);
      if ($urandom_range(99) < rpct) out_ready = 1'b1; else out_ready = 1'b0;
      gen_and_drive(vpct, maxlen, newpct);

      @(negedge clk);
      exp_rdy = '0;
      if (!reset && sb.size() < 2) begin
        if (open >= 0) exp_rdy[open] = 1'b1;
        else
          for (int k = 0; k < N; k++)
            if (in_valid[(ptr + k) % N]) begin
              exp_rdy[(ptr + k) % N] = 1'b1;
              break;
            end
      end
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      if (sb.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(sb[0].b.data));
        chk("out_channel", 64'(out_channel), 64'(sb[0].ch));
        chk("out_sop", 64'(out_sop), 64'(sb[0].b.sop));
        chk("out_eop", 64'(out_eop), 64'(sb[0].b.eop));
      end else if (was_reset) begin
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_channel", 64'(out_channel), 64'd0);
        chk("rst_out_sop_eop", 64'({out_sop, out_eop}), 64'd0);
      end

      acc_i = -1;
      for (int i = 0; i < N; i++) if (in_valid[i] && exp_rdy[i]) acc_i = i;
      drain = (sb.size() > 0) && out_ready;

      @(posedge clk); #1;
      was_reset = reset;
      if (reset) begin
        sb.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
        open = -1;
        ptr  = 0;
      end else begin
        if (drain) void'(sb.pop_front());
        if (acc_i >= 0) begin
          obeat_t o;
          o.ch = acc_i;
          o.b  = srcq[acc_i].pop_front();
          sb.push_back(o);
          if (o.b.eop) begin open = -1; ptr = (acc_i + 1) % N; end
          else open = acc_i;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
